// File: rtl/mux_key.sv
// mux_key: keyed lookup table with combinational and registered results.
//
// Ports
//   clk          clock; out_q/hit_q update on its rising edge
//   rst          synchronous active-high reset for out_q/hit_q only
//   key          selector compared against every table key
//   lut          packed table; entry i = lut[(i+1)*PAIR_LEN-1 -: PAIR_LEN],
//                key in the upper KEY_LEN bits, data in the lower DATA_LEN bits
//   default_out  miss value, used only when HAS_DEFAULT != 0
//   out, hit     combinational lookup result / any-entry-matched flag
//   out_q, hit_q out/hit registered on clk

// Per-entry comparator: splits one {key,data} pair and flags a key match.
module mux_key_entry #(
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic [KEY_LEN+DATA_LEN-1:0] i_pair,
  input  logic [KEY_LEN-1:0]          i_key,
  output logic                        o_match,
  output logic [DATA_LEN-1:0]         o_data
);
  assign o_match = (i_pair[KEY_LEN+DATA_LEN-1 -: KEY_LEN] == i_key);
  assign o_data  = i_pair[DATA_LEN-1:0];
endmodule

module mux_key #(
  parameter int NR_KEY      = 2,
  parameter int KEY_LEN     = 1,
  parameter int DATA_LEN    = 1,
  parameter int HAS_DEFAULT = 0,
  localparam int PAIR_LEN   = KEY_LEN + DATA_LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [KEY_LEN-1:0]         key,
  input  logic [NR_KEY*PAIR_LEN-1:0] lut,
  input  logic [DATA_LEN-1:0]        default_out,
  output logic [DATA_LEN-1:0]        out,
  output logic                       hit,
  output logic [DATA_LEN-1:0]        out_q,
  output logic                       hit_q
);
  logic [NR_KEY-1:0]               w_match;
  logic [NR_KEY-1:0][DATA_LEN-1:0] w_data;
  logic [DATA_LEN-1:0]             w_out;
  logic                            w_hit;
  logic [DATA_LEN-1:0]             r_out_q;
  logic                            r_hit_q;

  for (genvar g = 0; g < NR_KEY; g++) begin : g_ent
    mux_key_entry #(.KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) u_ent (
      .i_pair  (lut[(g+1)*PAIR_LEN-1 -: PAIR_LEN]),
      .i_key   (key),
      .o_match (w_match[g]),
      .o_data  (w_data[g])
    );
  end

  // Scan from the highest index down so the lowest-index match is written
  // last and therefore wins when the table holds duplicate keys.
  always_comb begin
    w_out = (HAS_DEFAULT != 0) ? default_out : '0;
    w_hit = 1'b0;
    for (int i = NR_KEY-1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_out = w_data[i];
        w_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_q <= '0;
      r_hit_q <= 1'b0;
    end else begin
      r_out_q <= w_out;
      r_hit_q <= w_hit;
    end
  end

  assign out   = w_out;
  assign hit   = w_hit;
  assign out_q = r_out_q;
  assign hit_q = r_hit_q;
endmodule

// File: tb/tb_mux_key.sv
module tb_mux_key;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 4-entry, 8-bit table
  logic [1:0]  k4;
  logic [39:0] lut4;
  logic [7:0]  dflt8 = 8'hFF;
  logic [7:0]  o4, o4q;
  logic        h4, h4q;
  // 3-entry, 16-bit table, without and with default
  logic [1:0]  k3;
  logic [53:0] lut3;
  logic [15:0] dflt16 = 16'hBEEF;
  logic [15:0] o3n, o3nq, o3d, o3dq;
  logic        h3n, h3nq, h3d, h3dq;
  // 2-entry duplicate-key table
  logic [1:0]  k2;
  logic [19:0] lut2;
  logic [7:0]  o2, o2q;
  logic        h2, h2q;

  mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8), .HAS_DEFAULT(0)) u4 (
    .clk(clk), .rst(rst), .key(k4), .lut(lut4), .default_out(dflt8),
    .out(o4), .hit(h4), .out_q(o4q), .hit_q(h4q));
  mux_key #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(16), .HAS_DEFAULT(0)) u3n (
    .clk(clk), .rst(rst), .key(k3), .lut(lut3), .default_out(dflt16),
    .out(o3n), .hit(h3n), .out_q(o3nq), .hit_q(h3nq));
  mux_key #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(16), .HAS_DEFAULT(1)) u3d (
    .clk(clk), .rst(rst), .key(k3), .lut(lut3), .default_out(dflt16),
    .out(o3d), .hit(h3d), .out_q(o3dq), .hit_q(h3dq));
  mux_key #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(8), .HAS_DEFAULT(0)) u2 (
    .clk(clk), .rst(rst), .key(k2), .lut(lut2), .default_out(dflt8),
    .out(o2), .hit(h2), .out_q(o2q), .hit_q(h2q));

  task automatic test_reset();
    // Two edges in reset; combinational path must stay live meanwhile.
    @(negedge clk); rst = 1'b1; k4 = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    total++; if (o4q !== 8'h00) begin bad++; $display("FAIL reset_out_q got=%h exp=00", o4q); end
    total++; if (h4q !== 1'b0)  begin bad++; $display("FAIL reset_hit_q got=%b exp=0", h4q); end
    total++; if (o4 !== 8'h33)  begin bad++; $display("FAIL reset_comb_out got=%h exp=33", o4); end
    total++; if (o3nq !== 16'h0 || o3dq !== 16'h0 || o2q !== 8'h0)
      begin bad++; $display("FAIL reset_other_q got=%h/%h/%h exp=0", o3nq, o3dq, o2q); end
  endtask

  task automatic test_lookup4();
    logic [7:0] exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11}; // index by key: 00->11 ... reversed below
    for (int i = 0; i < 4; i++) begin
      k4 = 2'(i);
      #1;
      total++; if (o4 !== exp[3-i] || h4 !== 1'b1)
        begin bad++; $display("FAIL lookup4 key=%0d got=%h/%b exp=%h/1", i, o4, h4, exp[3-i]); end
    end
  endtask

  task automatic test_miss();
    k3 = 2'b11; #1;
    total++; if (o3n !== 16'h0000 || h3n !== 1'b0)
      begin bad++; $display("FAIL miss_nodef got=%h/%b exp=0000/0", o3n, h3n); end
    total++; if (o3d !== 16'hBEEF || h3d !== 1'b0)
      begin bad++; $display("FAIL miss_def got=%h/%b exp=beef/0", o3d, h3d); end
    dflt16 = 16'h1234; #1;
    total++; if (o3d !== 16'h1234 || o3n !== 16'h0000)
      begin bad++; $display("FAIL miss_def_follow got=%h/%h exp=1234/0000", o3d, o3n); end
    dflt16 = 16'hBEEF;
    k3 = 2'b10; #1;
    total++; if (o3d !== 16'h3333 || h3d !== 1'b1 || o3n !== 16'h3333)
      begin bad++; $display("FAIL hit_def got=%h/%b/%h exp=3333/1/3333", o3d, h3d, o3n); end
    k3 = 2'b00; #1;
    total++; if (o3n !== 16'h1111 || h3n !== 1'b1)
      begin bad++; $display("FAIL hit3_k0 got=%h/%b exp=1111/1", o3n, h3n); end
  endtask

  task automatic test_duplicates();
    k2 = 2'b01; #1;
    total++; if (o2 !== 8'hBB || h2 !== 1'b1)
      begin bad++; $display("FAIL dup got=%h/%b exp=bb/1", o2, h2); end
    k2 = 2'b00; #1;
    total++; if (o2 !== 8'h00 || h2 !== 1'b0)
      begin bad++; $display("FAIL dup_miss got=%h/%b exp=00/0", o2, h2); end
    // Make only entry 1 match: its data must then appear.
    lut2 = {2'b01, 8'hAA, 2'b10, 8'hBB}; k2 = 2'b01; #1;
    total++; if (o2 !== 8'hAA || h2 !== 1'b1)
      begin bad++; $display("FAIL dup_entry1 got=%h/%b exp=aa/1", o2, h2); end
  endtask

  task automatic test_registered();
    @(negedge clk); k4 = 2'b10; rst = 1'b0;
    #1;
    total++; if (o4q !== 8'h00) begin bad++; $display("FAIL reg_before_edge got=%h exp=00", o4q); end
    @(posedge clk); #1;
    total++; if (o4q !== 8'h33 || h4q !== 1'b1)
      begin bad++; $display("FAIL reg_first got=%h/%b exp=33/1", o4q, h4q); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++; if (o4q !== 8'h00 || h4q !== 1'b0 || o4 !== 8'h33)
      begin bad++; $display("FAIL midrst got=%h/%b/%h exp=00/0/33", o4q, h4q, o4); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++; if (o4q !== 8'h33 || h4q !== 1'b1)
      begin bad++; $display("FAIL midrst_release got=%h/%b exp=33/1", o4q, h4q); end
  endtask

  task automatic test_mid_cycle();
    @(negedge clk); k4 = 2'b01; #1;
    total++; if (o4 !== 8'h22 || o4q !== 8'h33)
      begin bad++; $display("FAIL midcyc_a got=%h/%h exp=22/33", o4, o4q); end
    lut4[7:0] = 8'h55; k4 = 2'b11; #1;
    total++; if (o4 !== 8'h55 || o4q !== 8'h33)
      begin bad++; $display("FAIL midcyc_b got=%h/%h exp=55/33", o4, o4q); end
    @(posedge clk); #1;
    total++; if (o4q !== 8'h55) begin bad++; $display("FAIL midcyc_q got=%h exp=55", o4q); end
  endtask

  task automatic test_back_to_back();
    // Miss registered on one edge, hit on the next.
    @(negedge clk); k3 = 2'b11;
    @(posedge clk); #1;
    total++; if (o3nq !== 16'h0000 || h3nq !== 1'b0 || o3dq !== 16'hBEEF || h3dq !== 1'b0)
      begin bad++; $display("FAIL b2b_miss got=%h/%b/%h/%b exp=0000/0/beef/0", o3nq, h3nq, o3dq, h3dq); end
    @(negedge clk); k3 = 2'b01;
    @(posedge clk); #1;
    total++; if (o3nq !== 16'h2222 || h3nq !== 1'b1 || o3dq !== 16'h2222 || h3dq !== 1'b1)
      begin bad++; $display("FAIL b2b_hit got=%h/%b/%h/%b exp=2222/1/2222/1", o3nq, h3nq, o3dq, h3dq); end
  endtask

  initial begin
    k4 = '0; k3 = '0; k2 = '0;
    lut4 = {2'b00, 8'h11, 2'b01, 8'h22, 2'b10, 8'h33, 2'b11, 8'h44};
    lut3 = {2'b00, 16'h1111, 2'b01, 16'h2222, 2'b10, 16'h3333};
    lut2 = {2'b01, 8'hAA, 2'b01, 8'hBB};
    test_reset();
    test_lookup4();
    test_miss();
    test_duplicates();
    test_registered();
    test_mid_reset();
    test_mid_cycle();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
